// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet-sequencing controller.
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    WAIT_TILL_EMPTY    = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    LOAD_PARITY        = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  localparam logic [1:0] ADDR_P0  = 2'b00;
  localparam logic [1:0] ADDR_P1  = 2'b01;
  localparam logic [1:0] ADDR_P2  = 2'b10;
  localparam logic [1:0] ADDR_INV = 2'b11;

  function automatic logic addr_is_valid(input logic [1:0] addr);
    return addr != ADDR_INV;
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Counts cycles spent waiting for an empty FIFO and flags when the limit is hit.
// Only instantiated when ROUTER_FSM_WAIT_TIMEOUT_EN is defined.
module router_wait_timer #(
  parameter int WAIT_LIMIT = 63
) (
  input  logic clk,
  input  logic rstn,
  input  logic waiting,
  output logic expired
);

  logic [7:0] cnt_reg;

  // Held at zero outside the wait state, so every entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (!rstn || !waiting) begin
      cnt_reg <= 8'd0;
    end else if (cnt_reg != 8'hFF) begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

  // cnt_reg is the number of wait cycles already completed before this one.
  assign expired = waiting && (cnt_reg == 8'(WAIT_LIMIT - 1));

endmodule

// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router (header, payload, parity).
// Optional wait-state timeout: define ROUTER_FSM_WAIT_TIMEOUT_EN.
module router_fsm
  import router_pkg::*;
#(
  parameter int WAIT_LIMIT = 63
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_rst_0,
  input  logic       soft_rst_1,
  input  logic       soft_rst_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       full_state,
  output logic       laf_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy,
  output logic       drop_pkt
);

  state_t     state_reg;
  state_t     state_next;
  logic [1:0] addr_q;
  logic [3:0] empty_v;
  logic [3:0] soft_v;
  logic       soft_hit;
  logic       wait_expired;

  // Padded to four entries so the invalid address selects a constant 0.
  assign empty_v  = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_v   = {1'b0, soft_rst_2, soft_rst_1, soft_rst_0};
  assign soft_hit = soft_v[addr_q];

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  logic drop_next;
  logic drop_reg;

  router_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_wait_timer (
    .clk    (clk),
    .rstn   (rstn),
    .waiting(state_reg == WAIT_TILL_EMPTY),
    .expired(wait_expired)
  );

  // An empty FIFO or a soft reset in the same cycle means nothing is dropped.
  assign drop_next = (state_reg == WAIT_TILL_EMPTY) && wait_expired &&
                     !empty_v[addr_q] && !soft_hit;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      drop_reg <= 1'b0;
    end else begin
      drop_reg <= drop_next;
    end
  end

  assign drop_pkt = drop_reg;
`else
  assign wait_expired = 1'b0;
  assign drop_pkt     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= DECODE_ADDRESS;
      addr_q    <= ADDR_P0;
    end else begin
      state_reg <= state_next;
      if (state_reg == DECODE_ADDRESS && pkt_valid) begin
        addr_q <= data_in;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    if (soft_hit) begin
      state_next = DECODE_ADDRESS;
    end else begin
      case (state_reg)
        DECODE_ADDRESS: begin
          if (pkt_valid && addr_is_valid(data_in)) begin
            state_next = empty_v[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        WAIT_TILL_EMPTY: begin
          if (empty_v[addr_q]) begin
            state_next = LOAD_FIRST_DATA;
          end else if (wait_expired) begin
            state_next = DECODE_ADDRESS;
          end
        end
        LOAD_FIRST_DATA: state_next = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full) begin
            state_next = FIFO_FULL_STATE;
          end else if (!pkt_valid) begin
            state_next = LOAD_PARITY;
          end
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) begin
            state_next = LOAD_AFTER_FULL;
          end
        end
        LOAD_AFTER_FULL: begin
          if (parity_done) begin
            state_next = DECODE_ADDRESS;
          end else if (low_pkt_valid) begin
            state_next = LOAD_PARITY;
          end else begin
            state_next = LOAD_DATA;
          end
        end
        LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        default: state_next = DECODE_ADDRESS;
      endcase
    end
  end

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    full_state    = 1'b0;
    laf_state     = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b1;
    case (state_reg)
      DECODE_ADDRESS: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
      LOAD_FIRST_DATA: lfd_state = 1'b1;
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      FIFO_FULL_STATE: full_state = 1'b1;
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      LOAD_PARITY: write_enb_reg = 1'b1;
      CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
      default: busy = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// Randomized scoreboard bench for router_fsm against a packet-phase reference model.
// Honours ROUTER_FSM_WAIT_TIMEOUT_EN (short WAIT_LIMIT so timeouts actually occur).
module tb_router_fsm;

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  localparam int LIMIT = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int LIMIT = 63;
  localparam bit TO_EN = 1'b0;
`endif
  localparam int N_CYCLES = 4000;

  logic       clk = 1'b0;
  logic       rstn, pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_rst_0, soft_rst_1, soft_rst_2;
  logic       detect_add, lfd_state, ld_state, full_state, laf_state;
  logic       write_enb_reg, rst_int_reg, busy, drop_pkt;

  always #5 clk = ~clk;

  router_fsm #(.WAIT_LIMIT(LIMIT)) dut (
    .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_rst_0(soft_rst_0), .soft_rst_1(soft_rst_1),
    .soft_rst_2(soft_rst_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .full_state(full_state), .laf_state(laf_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy), .drop_pkt(drop_pkt)
  );

  // Packet phases as seen from the outside: idle/header-decode, waiting, header
  // write, payload, full hold, resume-after-full, parity write, parity check.
  typedef enum int {P_IDLE, P_WAIT, P_HDR, P_PAY, P_FULL, P_AFTER, P_PAR, P_CHK} phase_e;

  phase_e     m_phase = P_IDLE;
  logic [1:0] m_addr = 2'b00;
  int         m_waited = 0;
  bit         m_drop = 1'b0;

  logic [8:0] exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cycle = 0;

  function automatic bit chance(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  // Bit order: detect, lfd, ld, full, laf, we, rst_int, busy, drop.
  function automatic logic [8:0] outs_of(input phase_e p, input bit drop);
    logic [8:0] v;
    v[8] = (p == P_IDLE);
    v[7] = (p == P_HDR);
    v[6] = (p == P_PAY);
    v[5] = (p == P_FULL);
    v[4] = (p == P_AFTER);
    v[3] = (p == P_PAY) || (p == P_PAR) || (p == P_AFTER);
    v[2] = (p == P_CHK);
    v[1] = !((p == P_IDLE) || (p == P_PAY));
    v[0] = drop;
    return v;
  endfunction

  // Advance the model by one clock using the inputs currently on the bus.
  task automatic model_step();
    phase_e     nxt;
    bit         dropn;
    logic [3:0] emp;
    logic [3:0] srs;
    emp = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    srs = {1'b0, soft_rst_2, soft_rst_1, soft_rst_0};
    if (!rstn) begin
      m_phase = P_IDLE; m_addr = 2'b00; m_waited = 0; m_drop = 1'b0;
      return;
    end
    nxt = m_phase;
    dropn = 1'b0;
    if (srs[m_addr]) begin
      nxt = P_IDLE;
    end else begin
      case (m_phase)
        P_IDLE:  if (pkt_valid && data_in != 2'b11) nxt = emp[data_in] ? P_HDR : P_WAIT;
        P_WAIT: begin
          if (emp[m_addr]) nxt = P_HDR;
          else if (TO_EN && (m_waited + 1) >= LIMIT) begin
            nxt = P_IDLE;
            dropn = 1'b1;
          end
        end
        P_HDR:   nxt = P_PAY;
        P_PAY:   if (fifo_full) nxt = P_FULL; else if (!pkt_valid) nxt = P_PAR;
        P_FULL:  if (!fifo_full) nxt = P_AFTER;
        P_AFTER: nxt = parity_done ? P_IDLE : (low_pkt_valid ? P_PAR : P_PAY);
        P_PAR:   nxt = P_CHK;
        P_CHK:   nxt = fifo_full ? P_FULL : P_IDLE;
        default: nxt = P_IDLE;
      endcase
    end
    if (nxt == P_WAIT) m_waited = (m_phase == P_WAIT) ? m_waited + 1 : 0;
    if (m_phase == P_IDLE && pkt_valid) m_addr = data_in;
    m_phase = nxt;
    m_drop = dropn;
  endtask

  task automatic drive_random(input bit force_reset);
    rstn          = force_reset ? 1'b0 : !chance(2);
    pkt_valid     = chance(75);
    data_in       = 2'($urandom_range(3));
    fifo_full     = chance(20);
    fifo_empty_0  = chance(40);
    fifo_empty_1  = chance(40);
    fifo_empty_2  = chance(40);
    soft_rst_0    = chance(3);
    soft_rst_1    = chance(3);
    soft_rst_2    = chance(3);
    parity_done   = chance(15);
    low_pkt_valid = chance(20);
  endtask

  // Monitor: every cycle the DUT presents a fresh output vector just after the edge.
  initial begin
    logic [8:0] got;
    logic [8:0] exp;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        got = {detect_add, lfd_state, ld_state, full_state, laf_state,
               write_enb_reg, rst_int_reg, busy, drop_pkt};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL outputs cycle %0d: got %b required %b (detect,lfd,ld,full,laf,we,rst_int,busy,drop)",
                   cycle, got, exp);
        end
      end
    end
  end

  // Stimulus: drive inputs on the falling edge and push the post-edge expectation.
  initial begin
    drive_random(1'b1);
    model_step();
    exp_q.push_back(outs_of(m_phase, m_drop));
    for (int i = 0; i < N_CYCLES; i++) begin
      @(posedge clk);
      @(negedge clk);
      drive_random(i < 2);
      model_step();
      exp_q.push_back(outs_of(m_phase, m_drop));
    end
    @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: %0d entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
# router_fsm

Packet-sequencing controller for the 1x3 router. Tracks each incoming packet from header through payload to parity and drives the sequencing strobes for the input register block and the synchronizer. Also raises busy to stall the source. Sits between the source port (pkt_valid, data_in) and the synchronizer, register and FIFO blocks.

## Interface
- WAIT_LIMIT, default 63: cycles allowed in WAIT_TILL_EMPTY before the packet is dropped. Used only with the timeout feature; legal range 1–255.

- clk, input, 1: clock; all logic on posedge.
- rstn, input, 1: reset, synchronous, active-low.
- pkt_valid, input, 1: source has header or payload on the bus; deasserts with the parity byte.
- data_in, input, 2: header address bits [1:0] of the input byte.
- fifo_full, input, 1: full flag of the FIFO selected by the latched address.
- fifo_empty_0, fifo_empty_1, fifo_empty_2, input, 1 each: per-FIFO empty flags.
- soft_rst_0, soft_rst_1, soft_rst_2, input, 1 each: per-port timeout resets from the synchronizer.
- parity_done, input, 1: register block has loaded the parity byte.
- low_pkt_valid, input, 1: register block reports pkt_valid fell while the FIFO was full.
- detect_add, output, 1: header decode cycle; the synchronizer captures the address on this strobe.
- lfd_state, output, 1: load first data (header) into the FIFO.
- ld_state, output, 1: load payload.
- full_state, output, 1: FIFO-full hold.
- laf_state, output, 1: load after full.
- write_enb_reg, output, 1: FIFO write enable request to the synchronizer.
- rst_int_reg, output, 1: parity check / internal register clear.
- busy, output, 1: stall source.
- drop_pkt, output, 1: one-cycle pulse when a waiting packet is discarded.

## Operation
- The state register and a 2-bit addr_q are the only sequential state, plus the timer when the timeout feature is enabled.
- addr_q is loaded from data_in when state is DECODE_ADDRESS and pkt_valid=1.
- Address 2'b11 is invalid: the FSM stays in DECODE_ADDRESS and the byte is ignored.
- DECODE_ADDRESS:
  - pkt_valid, valid address, and the addressed fifo_empty_N=1 -> LOAD_FIRST_DATA.
  - pkt_valid, valid address, and fifo_empty_N=0 -> WAIT_TILL_EMPTY.
  - Otherwise hold.
- WAIT_TILL_EMPTY: fifo_empty[addr_q]=1 -> LOAD_FIRST_DATA; otherwise hold.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
- LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else hold.
- FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else hold.
- LOAD_AFTER_FULL:
  - parity_done -> DECODE_ADDRESS.
  - low_pkt_valid -> LOAD_PARITY.
  - Otherwise -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else DECODE_ADDRESS.
- Moore outputs:
  - detect_add=DECODE_ADDRESS, lfd_state=LOAD_FIRST_DATA, ld_state=LOAD_DATA, full_state=FIFO_FULL_STATE, laf_state=LOAD_AFTER_FULL, rst_int_reg=CHECK_PARITY_ERROR.
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
- Soft reset: soft_rst_N=1 with N==addr_q forces DECODE_ADDRESS on the next edge from any state. It overrides every transition except rstn. soft_rst on a non-selected port is ignored.

## Timing
- All transitions are registered. Outputs change on the edge after the qualifying input is sampled.
- Header at an empty FIFO: detect_add in cycle 0, lfd_state in cycle 1, ld_state from cycle 2.
- Parity: the first cycle with pkt_valid=0 in LOAD_DATA gives LOAD_PARITY on the next edge, then CHECK_PARITY_ERROR one cycle later.
- Reset values: state=DECODE_ADDRESS and addr_q=0. detect_add=1; all other outputs 0, including busy and drop_pkt.
- rstn mid-packet returns to DECODE_ADDRESS on the next edge, and no write_enb_reg is issued in that cycle.
- Simultaneous fifo_full and !pkt_valid in LOAD_DATA: fifo_full wins.

## Configuration
- ROUTER_FSM_WAIT_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to WAIT_TILL_EMPTY and increments each cycle spent there.
  - When the count reaches WAIT_LIMIT with the FIFO still non-empty, the FSM goes to DECODE_ADDRESS and drop_pkt pulses high for one cycle.
  - fifo_empty in the same cycle wins over the timeout.
- ROUTER_FSM_WAIT_TIMEOUT_EN undefined: no counter; WAIT_TILL_EMPTY waits indefinitely; drop_pkt is tied to 0.

## Structure
- router_pkg holds:
  - The 3-bit state enum (8 states, binary encoded, DECODE_ADDRESS=0).
  - Port address constants ADDR_P0=2'b00, ADDR_P1=2'b01, ADDR_P2=2'b10, ADDR_INV=2'b11.
- One sub-module, router_wait_timer: counter plus limit compare, instantiated only under the macro.

## Test plan
- Reset, then pkt_valid=1, data_in=2'b01, fifo_empty_1=1 -> detect_add, then lfd_state, then ld_state plus write_enb_reg on consecutive cycles, with busy=0 in LOAD_DATA.
- In LOAD_DATA, drop pkt_valid -> LOAD_PARITY (write_enb_reg=1, busy=1), then CHECK_PARITY_ERROR (rst_int_reg=1), then detect_add.
- fifo_full=1 in LOAD_DATA for 3 cycles, then 0 with low_pkt_valid=1 -> full_state for 3 cycles, then laf_state, then LOAD_PARITY.
- Header to port 2 with fifo_empty_2=0 for 10 cycles -> WAIT_TILL_EMPTY with busy=1; fifo_empty_2 rises -> lfd_state on the next edge.
- Mid-payload to port 0: soft_rst_1=1 -> no effect; soft_rst_0=1 -> detect_add=1 on the next edge.
- With the macro and WAIT_LIMIT=4, fifo_empty_0 held at 0 -> drop_pkt pulses once, after 4 cycles in WAIT_TILL_EMPTY, and the FSM returns to DECODE_ADDRESS.
